// File: rtl/sc_pkg.sv
// Shared constants and state type for the Sobol stochastic-computing stream.
// Holds default WIDTH/LEN/TMO, the ones-count width and the frame FSM states.
package sc_pkg;

  localparam int WIDTH_D = 6;
  localparam int LEN_D   = 64;
  localparam int TMO_D   = 16;
  localparam int ONES_W  = WIDTH_D + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/sc_watchdog.sv
// Stall watchdog: counts enabled cycles without a clear and flags the limit.
// Ports: clk, rst (sync, high), en, clr, hit (asserts on the TMO-th idle cycle).
module sc_watchdog #(
  parameter int TMO = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic hit
);

  localparam int CW = $clog2(TMO + 1);

  logic [CW-1:0] cnt;

  // hit is next-state only; the caller registers its effect
  assign hit = en && !clr && (cnt == CW'(TMO - 1));

  always_ff @(posedge clk) begin
    if (rst || !en || clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sobol_sc_stream.sv
// Sequences one Sobol generator and turns its samples into stochastic bits,
// counting ones per LEN-sample frame. Ports: start/x in, busy, gen_en,
// gen_count to the generator, smp_valid/smp from it, bit_valid/bit_out,
// done/ones/err out. Build with SC_TIMEOUT_EN to enable the stall watchdog.
module sobol_sc_stream
  import sc_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int LEN   = LEN_D,
  parameter int TMO   = TMO_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             gen_en,
  output logic [WIDTH-1:0] gen_count,
  input  logic             smp_valid,
  input  logic [WIDTH-1:0] smp,
  output logic             bit_valid,
  output logic             bit_out,
  output logic             done,
  output logic [WIDTH:0]   ones,
  output logic             err
);

  localparam int OW = WIDTH + 1;

  state_t           state;
  logic [WIDTH-1:0] x_lat;
  logic             take;
  logic             last;
  logic             bit_c;
  logic             hit;

  assign take  = (state == RUN) && gen_en && smp_valid;
  assign last  = (gen_count == WIDTH'(LEN - 1));
  assign bit_c = (smp < x_lat);

`ifdef SC_TIMEOUT_EN
  sc_watchdog #(
    .TMO (TMO)
  ) u_wdg (
    .clk (clk),
    .rst (rst),
    .en  (state == RUN),
    .clr (smp_valid),
    .hit (hit)
  );
`else
  logic unused_tmo;
  assign unused_tmo = (TMO != 0);
  assign hit        = 1'b0;
`endif

  // gen_count doubles as the frame point index
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x_lat     <= '0;
      busy      <= 1'b0;
      gen_en    <= 1'b0;
      gen_count <= '0;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
      done      <= 1'b0;
      ones      <= '0;
      err       <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            x_lat     <= x;
            gen_count <= '0;
            ones      <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            gen_en    <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (take) begin
            bit_valid <= 1'b1;
            bit_out   <= bit_c;
            ones      <= ones + OW'(bit_c);
            gen_count <= gen_count + 1'b1;
            if (last) begin
              done   <= 1'b1;
              gen_en <= 1'b0;
              state  <= DONE;
            end
          end else if (hit) begin
            done   <= 1'b1;
            err    <= 1'b1;
            gen_en <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobol_sc_stream.sv
// Directed bench for sobol_sc_stream with a bit-reversal Sobol model.
// Covers full frames, boundary operands, ignored inputs, reset and stalls.
module tb_sobol_sc_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] x;
  logic       busy;
  logic       gen_en;
  logic [5:0] gen_count;
  logic       smp_valid;
  logic [5:0] smp;
  logic       bit_valid;
  logic       bit_out;
  logic       done;
  logic [6:0] ones;
  logic       err;

  sobol_sc_stream dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x         (x),
    .busy      (busy),
    .gen_en    (gen_en),
    .gen_count (gen_count),
    .smp_valid (smp_valid),
    .smp       (smp),
    .bit_valid (bit_valid),
    .bit_out   (bit_out),
    .done      (done),
    .ones      (ones),
    .err       (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] brev(input logic [5:0] v);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = v[5-i];
    return r;
  endfunction

  // Generator model: one sample every 3 enabled cycles
  logic inject = 1'b0;
  int   limit  = 1000;
  int   gap    = 0;
  int   sent   = 0;

  initial begin
    smp_valid = 1'b0;
    smp       = '0;
    forever begin
      @(posedge clk);
      #2;
      smp_valid = 1'b0;
      if (inject) begin
        smp_valid = 1'b1;
        smp       = 6'd5;
      end else if (gen_en === 1'b1) begin
        gap++;
        if (gap == 3) begin
          gap = 0;
          if (sent < limit) begin
            smp_valid = 1'b1;
            smp       = brev(gen_count);
            sent++;
          end
        end
      end else begin
        gap  = 0;
        sent = 0;
      end
    end
  end

  // Monitor
  int   cyc      = 0;
  int   nbv      = 0;
  int   nhigh    = 0;
  int   ndone    = 0;
  int   ndone_bv = 0;
  int   gc_bad   = 0;
  int   fk       = 0;
  int   last_bv  = 0;
  int   done_cyc = 0;
  logic busy_d   = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (busy && !busy_d) begin
        fk = 0;
        if (gen_count != 6'd0) gc_bad++;
      end
      if (bit_valid) begin
        nbv++;
        nhigh += int'(bit_out);
        fk++;
        if (gen_count != 6'(fk)) gc_bad++;
        last_bv = cyc;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        if (bit_valid) ndone_bv++;
      end
      busy_d = busy;
    end
  end

  task automatic wait_done(input int base, input int maxc,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      #1;
      if (ndone > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bv(input int target, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (nbv >= target) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_reach"}, int'(ok), 1);
  endtask

  task automatic run_frame(input logic [5:0] xv, input int expo,
                           input bit disturb, input string tag);
    int b_bv, b_hi, b_dn, b_dbv, b_gc;
    bit ok;
    b_bv  = nbv;
    b_hi  = nhigh;
    b_dn  = ndone;
    b_dbv = ndone_bv;
    b_gc  = gc_bad;
    if (disturb) begin
      inject = 1'b1;
      repeat (2) @(posedge clk);
      #1;
    end
    x     = xv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    inject = 1'b0;
    if (disturb) begin
      wait_bv(b_bv + 10, tag);
      @(posedge clk);
      #1;
      x     = 6'd9;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_done(b_dn, 400, ok);
    chk({tag, "_done"}, int'(ok), 1);
    chk({tag, "_ones"}, int'(ones), expo);
    chk({tag, "_nbv"}, nbv - b_bv, 64);
    chk({tag, "_nhigh"}, nhigh - b_hi, expo);
    chk({tag, "_done_bv"}, ndone_bv - b_dbv, 1);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_gc"}, gc_bad - b_gc, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_gen_en"}, int'(gen_en), 0);
    chk({tag, "_gcount"}, int'(gen_count), 0);
    chk({tag, "_bv"}, int'(bit_valid), 0);
    chk({tag, "_bit"}, int'(bit_out), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_ones"}, int'(ones), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int  b_bv, b_dn;
    bit  ok;
    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_frame(6'd37, 37, 1'b0, "f37");
    run_frame(6'd0, 0, 1'b0, "x0");
    run_frame(6'd63, 63, 1'b0, "x63");
    run_frame(6'd20, 20, 1'b1, "ign");

    // Reset in the middle of a frame
    b_bv  = nbv;
    x     = 6'd50;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_bv(b_bv + 20, "mid");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("mrst");
    @(posedge clk);
    #1;
    run_frame(6'd50, 50, 1'b0, "x50");

    // Generator stalls after 10 samples
    limit = 10;
    b_bv  = nbv;
    b_dn  = ndone;
    x     = 6'd32;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef SC_TIMEOUT_EN
    wait_done(b_dn, 300, ok);
    chk("tmo_done", int'(ok), 1);
    chk("tmo_err", int'(err), 1);
    chk("tmo_ones", int'(ones), 5);
    chk("tmo_nbv", nbv - b_bv, 10);
    chk("tmo_gap", done_cyc - last_bv, 16);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("tmo_err_hold", int'(err), 1);
    @(posedge clk);
    #1;
    limit = 1000;
`else
    ok = 1'b0;
    repeat (130) @(negedge clk);
    #1;
    chk("stall_busy", int'(busy), 1);
    chk("stall_done", ndone - b_dn, 0);
    chk("stall_err", int'(err), 0);
    chk("stall_nbv", nbv - b_bv, 10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    limit = 1000;
    @(negedge clk);
    chk("stall_rst_busy", int'(busy), 0);
    chk("stall_ok", int'(ok), 0);
    @(posedge clk);
    #1;
`endif
    run_frame(6'd37, 37, 1'b0, "after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sobol_sc_stream.md
Name: sobol_sc_stream

Overview:
Sequencing stage wrapped around one single-dimension Sobol generator.
- Drives the generator's enable and point index.
- Consumes each Sobol sample and compares it against a latched operand to emit one stochastic-computing bit per sample.
- Counts the ones over a full frame of LEN samples and reports the total on completion.
- Sits between the operand source (upstream) and the stochastic arithmetic datapath (downstream).

Parameters:
WIDTH, 6, bit width of Sobol samples and operand
LEN, 64, samples per frame; must equal 2**WIDTH
TMO, 16, watchdog limit in cycles without a sample (used only with SC_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle request to begin a frame; ignored unless IDLE
x  in  WIDTH  operand; sampled on accepted start
busy  out  1  high in RUN and DONE
gen_en  out  1  enable to Sobol generator; high only in RUN
gen_count  out  WIDTH  current point index to Sobol generator
smp_valid  in  1  one-cycle pulse from generator: smp is valid
smp  in  WIDTH  Sobol sample
bit_valid  out  1  one-cycle pulse: bit_out is valid
bit_out  out  1  stochastic bit = (smp < x_lat)
done  out  1  one-cycle pulse at end of frame
ones  out  WIDTH+1  count of 1-bits in frame, range 0..LEN
err  out  1  frame aborted by watchdog; constant 0 when feature is off

Behaviour:
- Reset (rst=1 at a clock edge), including mid-frame:
  - State returns to IDLE.
  - busy, gen_en, bit_valid, bit_out, done, err, ones, gen_count, idx and x_lat all go to 0.
- IDLE:
  - On start=1: x_lat<=x, idx<=0, ones<=0, err<=0, go to RUN.
  - smp_valid is ignored in IDLE, including when it coincides with start.
- RUN:
  - gen_en=1 and gen_count=idx, both registered.
  - gen_en stays high for the whole frame; the generator pulses smp_valid once per point.
  - On smp_valid, the next cycle gives:
    - bit_valid=1
    - bit_out=(smp<x_lat), unsigned
    - ones<=ones+bit
    - idx<=idx+1, wrapping to 0 after LEN-1
- Frame end: when smp_valid arrives with idx==LEN-1, the next state is DONE.
- DONE (exactly one cycle):
  - done=1 together with the final bit_valid; ones already includes the final bit.
  - gen_en=0, then return to IDLE.
  - ones holds until the next accepted start.
- Comparison boundaries:
  - x=0 gives all-zero bits.
  - For a full-period sample set that is a permutation of 0..LEN-1, ones == x exactly.
  - ones never exceeds LEN; the width WIDTH+1 holds 64.
- Overlaps:
  - start while busy is ignored.
  - A smp_valid in the same cycle as done, or while gen_en=0, is ignored.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
Macro: SC_TIMEOUT_EN.
- Defined:
  - In RUN, a watchdog counts consecutive cycles without smp_valid and clears on each smp_valid.
  - When it reaches TMO, the next state is DONE with done=1 and err=1.
  - ones holds the partial count; err holds until the next accepted start or rst.
- Undefined:
  - No watchdog logic; err is tied to 0.
  - RUN waits indefinitely for samples.

Decomposition:
- Package sc_pkg holds:
  - WIDTH, LEN and TMO defaults
  - state typedef {IDLE, RUN, DONE}
  - the ones-width constant WIDTH+1
- One sub-module, sc_watchdog (counter, clear, limit flag), instantiated only under SC_TIMEOUT_EN.
- The comparator and counters stay inline.

Test Plan:
- Basic frame: x=37, bench model returns a permutation of 0..63, one sample every 3 cycles.
  Required: 64 bit_valid pulses, gen_count steps 0..63, ones=37, done pulse coincides with the 64th bit_valid, err=0.
- Boundary operands: x=0, then x=63, back-to-back frames with start issued the cycle after done.
  Required: first frame ones=0 with no bit_out highs; second frame ones=63.
- Ignored inputs: start pulsed while busy, and smp_valid driven while in IDLE.
  Required: frame unaffected, ones and gen_count sequence unchanged, no extra bit_valid.
- Reset mid-frame: rst at sample 20 of x=50.
  Required: next cycle all outputs 0 and state IDLE; a new start then gives a clean frame with ones=50.
- Timeout (SC_TIMEOUT_EN defined, TMO=16): stall smp_valid after 10 samples.
  Required: done=1 and err=1 exactly 16 cycles after the last sample; ones equals the count of those 10 bits.
- Same stall with the macro undefined.
  Required: busy stays high with no done for 100 cycles and err stays 0.
